alu_fwd_hazard_core: RTL and testbench

// - Execute-stage ALU, decode-stage operand-forwarding selector and load-use hazard detector for the 5-stage MIPS pipeline.
// - The ALU computes the result and zero flag for the E stage.
// - Forwarding produces the 3-bit operand-source selects consumed by the decode-stage A/B muxes.
// - Hazard logic stalls PC and F/D, and bubbles D/E.
// - A registered stall counter is the only sequential state.

---
 rtl/alu_fwd_hazard_core.sv | 132 +++++++++++++
 tb/tb_alu_fwd_hazard_core.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fwd_hazard_core.sv
// rtl/alu_fwd_hazard_core.sv - E-stage ALU, D-stage forwarding selects, load-use stall and stall counter
module alu_fwd_hazard_core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [4:0]  shamt,
  input  logic [4:0]  alu_op,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [5:0]  opcode_d,
  input  logic        regwrite_e,
  input  logic        memtoreg_e,
  input  logic        memread_e,
  input  logic [4:0]  write_reg_e,
  input  logic        regwrite_m,
  input  logic        memtoreg_m,
  input  logic [4:0]  write_reg_m,
  input  logic        regwrite_w,
  input  logic        datac_w,
  input  logic [4:0]  write_reg_w,
  output logic [2:0]  asrc,
  output logic [2:0]  bsrc,
  output logic        stall,
  output logic [31:0] stall_cnt
);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_LUI   = 5'd8;
  localparam logic [4:0] OP_PASSB = 5'd9;
  localparam logic [4:0] OP_SLL   = 5'd10;
  localparam logic [4:0] OP_SRL   = 5'd11;
  localparam logic [4:0] OP_SRA   = 5'd12;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  logic        rs_hit;
  logic        rt_hit;
  logic [31:0] stall_cnt_q;

  // Priority-ordered forwarding source for one D-stage source register.
  // Youngest producer wins; E-stage loads are skipped because their data
  // does not exist yet (the stall covers that case). Register 0 is hardwired.
  function automatic logic [2:0] fwd_sel(
    input logic [4:0] x,
    input logic       rw_e,
    input logic       mtr_e,
    input logic [4:0] wr_e,
    input logic       rw_m,
    input logic       mtr_m,
    input logic [4:0] wr_m,
    input logic       rw_w,
    input logic       dc_w,
    input logic [4:0] wr_w
  );
    logic [2:0] sel;
    sel = 3'b000;
    if (x == 5'd0)                             sel = 3'b000;
    else if (rw_e && !mtr_e && (wr_e == x))    sel = 3'b001;
    else if (rw_m && !mtr_m && (wr_m == x))    sel = 3'b011;
    else if (rw_m &&  mtr_m && (wr_m == x))    sel = 3'b010;
    else if (rw_w &&  dc_w  && (wr_w == x))    sel = 3'b101;
    else if (rw_w && !dc_w  && (wr_w == x))    sel = 3'b100;
    return sel;
  endfunction

  // ALU result selection; unused op codes produce zero.
  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      OP_ADD:   alu_result = alu_a + alu_b;
      OP_SUB:   alu_result = alu_a - alu_b;
      OP_AND:   alu_result = alu_a & alu_b;
      OP_OR:    alu_result = alu_a | alu_b;
      OP_XOR:   alu_result = alu_a ^ alu_b;
      OP_NOR:   alu_result = ~(alu_a | alu_b);
      OP_SLT:   alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      OP_SLTU:  alu_result = {31'd0, (alu_a < alu_b)};
      OP_LUI:   alu_result = {alu_b[15:0], 16'd0};
      OP_PASSB: alu_result = alu_b;
      OP_SLL:   alu_result = alu_b << shamt;
      OP_SRL:   alu_result = alu_b >> shamt;
      OP_SRA:   alu_result = $unsigned($signed(alu_b) >>> shamt);
      default:  alu_result = 32'd0;
    endcase
  end

  assign alu_zero = (alu_result == 32'd0);

  // Operand-source selects for the decode-stage A (rs) and B (rt) muxes.
  always_comb begin
    asrc = fwd_sel(rs_d, regwrite_e, memtoreg_e, write_reg_e,
                   regwrite_m, memtoreg_m, write_reg_m,
                   regwrite_w, datac_w, write_reg_w);
    bsrc = fwd_sel(rt_d, regwrite_e, memtoreg_e, write_reg_e,
                   regwrite_m, memtoreg_m, write_reg_m,
                   regwrite_w, datac_w, write_reg_w);
  end

  // Load-use detection: rs is ignored for jumps, rt only matters for
  // instructions that actually read it in D (R-type, SW, BEQ, BNE).
  always_comb begin
    rs_hit = (write_reg_e == rs_d) && (opcode_d != OPC_J) && (opcode_d != OPC_JAL);
    rt_hit = (write_reg_e == rt_d) &&
             ((opcode_d == OPC_RTYPE) || (opcode_d == OPC_SW) ||
              (opcode_d == OPC_BEQ)   || (opcode_d == OPC_BNE));
    stall  = memread_e && regwrite_e && (write_reg_e != 5'd0) && (rs_hit || rt_hit);
  end

  // Stall cycle counter; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        stall_cnt_q <= 32'd0;
    else if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_alu_fwd_hazard_core.sv
// tb/tb_alu_fwd_hazard_core.sv - table-driven scoreboard bench for alu_fwd_hazard_core
module tb_alu_fwd_hazard_core;

  logic        clk;
  logic        rst;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  shamt, alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [4:0]  rs_d, rt_d;
  logic [5:0]  opcode_d;
  logic        regwrite_e, memtoreg_e, memread_e;
  logic [4:0]  write_reg_e;
  logic        regwrite_m, memtoreg_m;
  logic [4:0]  write_reg_m;
  logic        regwrite_w, datac_w;
  logic [4:0]  write_reg_w;
  logic [2:0]  asrc, bsrc;
  logic        stall;
  logic [31:0] stall_cnt;

  alu_fwd_hazard_core dut (
    .clk(clk), .rst(rst),
    .alu_a(alu_a), .alu_b(alu_b), .shamt(shamt), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rs_d(rs_d), .rt_d(rt_d), .opcode_d(opcode_d),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memread_e(memread_e),
    .write_reg_e(write_reg_e),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .write_reg_m(write_reg_m),
    .regwrite_w(regwrite_w), .datac_w(datac_w), .write_reg_w(write_reg_w),
    .asrc(asrc), .bsrc(bsrc), .stall(stall), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard entry: which output to look at and what it must read.
  typedef enum int {S_RES, S_ZERO, S_ASRC, S_BSRC, S_STALL, S_CNT} sig_t;
  typedef struct {
    string       name;
    sig_t        sig;
    logic [31:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] res;
    logic        zero;
  } alu_vec_t;

  typedef struct {
    logic [4:0] rs, rt;
    logic       rw_e, mtr_e; logic [4:0] wr_e;
    logic       rw_m, mtr_m; logic [4:0] wr_m;
    logic       rw_w, dc_w;  logic [4:0] wr_w;
    logic [2:0] a_sel, b_sel;
  } fwd_vec_t;

  typedef struct {
    logic [5:0] opc;
    logic [4:0] rs, rt;
    logic       mr_e, rw_e;
    logic [4:0] wr_e;
    logic       exp_stall;
  } stall_vec_t;

  alu_vec_t   alu_tab[15];
  fwd_vec_t   fwd_tab[9];
  stall_vec_t stall_tab[8];
  logic [31:0] exp_cnt;

  task automatic expect_val(input string name, input sig_t sig, input logic [31:0] exp);
    sb_t e;
    e.name = name; e.sig = sig; e.exp = exp;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] actual_of(input sig_t sig);
    case (sig)
      S_RES:   return alu_result;
      S_ZERO:  return {31'd0, alu_zero};
      S_ASRC:  return {29'd0, asrc};
      S_BSRC:  return {29'd0, bsrc};
      S_STALL: return {31'd0, stall};
      default: return stall_cnt;
    endcase
  endfunction

  // Pop every pending expectation and compare against the live outputs.
  task automatic drain;
    sb_t e;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = actual_of(e.sig);
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic clear_ctrl;
    alu_a = 0; alu_b = 0; shamt = 0; alu_op = 0;
    rs_d = 0; rt_d = 0; opcode_d = 6'b100011;
    regwrite_e = 0; memtoreg_e = 0; memread_e = 0; write_reg_e = 0;
    regwrite_m = 0; memtoreg_m = 0; write_reg_m = 0;
    regwrite_w = 0; datac_w = 0; write_reg_w = 0;
  endtask

  initial begin
    alu_tab[0]  = '{5'd0,  32'h7,        32'hFFFFFFFF, 5'd0,  32'h6,        1'b0};
    alu_tab[1]  = '{5'd1,  32'h5,        32'h5,        5'd0,  32'h0,        1'b1};
    alu_tab[2]  = '{5'd6,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0};
    alu_tab[3]  = '{5'd7,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1};
    alu_tab[4]  = '{5'd12, 32'h0,        32'h80000000, 5'd4,  32'hF8000000, 1'b0};
    alu_tab[5]  = '{5'd20, 32'h5,        32'h6,        5'd0,  32'h0,        1'b1};
    alu_tab[6]  = '{5'd2,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000, 1'b0};
    alu_tab[7]  = '{5'd3,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000FFF0, 1'b0};
    alu_tab[8]  = '{5'd4,  32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h00000FF0, 1'b0};
    alu_tab[9]  = '{5'd5,  32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0};
    alu_tab[10] = '{5'd8,  32'h0,        32'hABCD1234, 5'd0,  32'h12340000, 1'b0};
    alu_tab[11] = '{5'd9,  32'h1,        32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0};
    alu_tab[12] = '{5'd10, 32'h0,        32'h1,        5'd31, 32'h80000000, 1'b0};
    alu_tab[13] = '{5'd11, 32'h0,        32'h80000000, 5'd4,  32'h08000000, 1'b0};
    alu_tab[14] = '{5'd13, 32'h3,        32'h4,        5'd0,  32'h0,        1'b1};

    //              rs  rt  E(rw,mtr,wr)   M(rw,mtr,wr)   W(rw,dc,wr)    asrc    bsrc
    fwd_tab[0] = '{5'd8, 5'd0, 1,0,5'd8,  1,1,5'd8,  1,0,5'd8,  3'b001, 3'b000};
    fwd_tab[1] = '{5'd8, 5'd0, 0,0,5'd8,  1,1,5'd8,  1,0,5'd8,  3'b010, 3'b000};
    fwd_tab[2] = '{5'd8, 5'd0, 0,0,5'd8,  0,1,5'd8,  1,0,5'd8,  3'b100, 3'b000};
    fwd_tab[3] = '{5'd8, 5'd0, 0,0,5'd8,  0,1,5'd8,  1,1,5'd8,  3'b101, 3'b000};
    fwd_tab[4] = '{5'd0, 5'd0, 1,0,5'd0,  1,0,5'd0,  1,1,5'd0,  3'b000, 3'b000};
    fwd_tab[5] = '{5'd4, 5'd5, 0,0,5'd0,  1,0,5'd5,  1,0,5'd4,  3'b100, 3'b011};
    fwd_tab[6] = '{5'd6, 5'd7, 1,1,5'd6,  1,0,5'd6,  0,0,5'd0,  3'b011, 3'b000};
    fwd_tab[7] = '{5'd3, 5'd3, 0,0,5'd0,  0,0,5'd0,  0,1,5'd3,  3'b000, 3'b000};
    fwd_tab[8] = '{5'd10,5'd10,1,0,5'd10, 1,1,5'd10, 1,1,5'd10, 3'b001, 3'b001};

    //                opcode      rs    rt    mr rw wr    stall
    stall_tab[0] = '{6'b000000, 5'd1, 5'd9, 1, 1, 5'd9, 1'b1};
    stall_tab[1] = '{6'b100011, 5'd3, 5'd9, 1, 1, 5'd9, 1'b0};
    stall_tab[2] = '{6'b000000, 5'd0, 5'd0, 1, 1, 5'd0, 1'b0};
    stall_tab[3] = '{6'b100011, 5'd9, 5'd2, 1, 1, 5'd9, 1'b1};
    stall_tab[4] = '{6'b000010, 5'd9, 5'd9, 1, 1, 5'd9, 1'b0};
    stall_tab[5] = '{6'b101011, 5'd1, 5'd9, 1, 1, 5'd9, 1'b1};
    stall_tab[6] = '{6'b000100, 5'd2, 5'd9, 1, 1, 5'd9, 1'b1};
    stall_tab[7] = '{6'b000000, 5'd9, 5'd9, 0, 1, 5'd9, 1'b0};

    // Reset: counter cleared, combinational paths still live.
    clear_ctrl();
    rst = 1'b1;
    alu_op = 5'd0; alu_a = 32'd2; alu_b = 32'd3;
    #12;
    expect_val("reset_cnt", S_CNT, 32'd0);
    expect_val("reset_alu", S_RES, 32'd5);
    drain();
    @(negedge clk);
    rst = 1'b0;
    clear_ctrl();

    // ALU table.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      alu_op = alu_tab[i].op; alu_a = alu_tab[i].a;
      alu_b = alu_tab[i].b;   shamt = alu_tab[i].sh;
      expect_val($sformatf("alu_res[%0d]", i), S_RES, alu_tab[i].res);
      expect_val($sformatf("alu_zero[%0d]", i), S_ZERO, {31'd0, alu_tab[i].zero});
      #1 drain();
    end

    // Forwarding table (memread_e held low so no stall can occur).
    clear_ctrl();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rs_d = fwd_tab[i].rs; rt_d = fwd_tab[i].rt;
      regwrite_e = fwd_tab[i].rw_e; memtoreg_e = fwd_tab[i].mtr_e; write_reg_e = fwd_tab[i].wr_e;
      regwrite_m = fwd_tab[i].rw_m; memtoreg_m = fwd_tab[i].mtr_m; write_reg_m = fwd_tab[i].wr_m;
      regwrite_w = fwd_tab[i].rw_w; datac_w = fwd_tab[i].dc_w;     write_reg_w = fwd_tab[i].wr_w;
      expect_val($sformatf("asrc[%0d]", i), S_ASRC, {29'd0, fwd_tab[i].a_sel});
      expect_val($sformatf("bsrc[%0d]", i), S_BSRC, {29'd0, fwd_tab[i].b_sel});
      #1 drain();
    end

    // Stall table; each vector is held across one rising edge so the
    // counter should advance once per expected stall.
    clear_ctrl();
    @(negedge clk);
    expect_val("cnt_before_stalls", S_CNT, 32'd0);
    drain();
    exp_cnt = 32'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        expect_val($sformatf("cnt_after[%0d]", i - 1), S_CNT, exp_cnt);
      end
      opcode_d = stall_tab[i].opc; rs_d = stall_tab[i].rs; rt_d = stall_tab[i].rt;
      memread_e = stall_tab[i].mr_e; regwrite_e = stall_tab[i].rw_e;
      memtoreg_e = stall_tab[i].mr_e; write_reg_e = stall_tab[i].wr_e;
      expect_val($sformatf("stall[%0d]", i), S_STALL, {31'd0, stall_tab[i].exp_stall});
      #1 drain();
      if (stall_tab[i].exp_stall) exp_cnt = exp_cnt + 32'd1;
    end
    @(negedge clk);
    clear_ctrl();
    expect_val("cnt_after_table", S_CNT, exp_cnt);
    #1 drain();

    // Exactly three stall cycles from a fresh count.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(negedge clk);
    opcode_d = 6'b000000; rt_d = 5'd9; write_reg_e = 5'd9;
    memread_e = 1'b1; regwrite_e = 1'b1; memtoreg_e = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear_ctrl();
    expect_val("cnt_three_stalls", S_CNT, 32'd3);
    #1 drain();

    // Asynchronous reset between edges, while a stall is being requested.
    opcode_d = 6'b000000; rt_d = 5'd9; write_reg_e = 5'd9;
    memread_e = 1'b1; regwrite_e = 1'b1; memtoreg_e = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    expect_val("cnt_async_reset", S_CNT, 32'd0);
    expect_val("stall_during_reset", S_STALL, 32'd1);
    drain();
    @(posedge clk);
    #1;
    expect_val("cnt_held_in_reset", S_CNT, 32'd0);
    drain();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_val("cnt_after_release", S_CNT, 32'd1);
    drain();
    clear_ctrl();

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion expected completion before 100000");
    $fatal(1, "timeout");
  end

endmodule
